// File: rtl/aoi_4input.sv
// AND-OR-INVERT cell with a registered, pipelined copy of the result
// and a saturating counter of output changes.
module aoi_4input #(
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 8
) (
  output logic             y,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             clk,
  input  logic             rst,
  output logic             y_q,
  output logic [CNT_W-1:0] chg_cnt
);

  generate
    if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_pipe
      $error("aoi_4input: PIPE_STAGES out of range 1..8");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
      $error("aoi_4input: CNT_W out of range 1..32");
    end
  endgenerate

  assign y = ~((a & b) | (c & d));

  // Reset asserts at once; release waits two edges so it lands cleanly.
  logic [1:0] rst_sync;
  logic       run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= '0;
    else     rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  logic [PIPE_STAGES-1:0] pipe;
  logic [PIPE_STAGES-1:0] pipe_nxt;

  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign pipe_nxt = y;
    end else begin : g_many
      assign pipe_nxt = {pipe[PIPE_STAGES-2:0], y};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pipe <= '1;
    else if (run) pipe <= pipe_nxt;
  end

  assign y_q = pipe[PIPE_STAGES-1];

  logic chg;
  logic sat;

  assign chg = pipe_nxt[PIPE_STAGES-1] != pipe[PIPE_STAGES-1];
  assign sat = &chg_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     chg_cnt <= '0;
    else if (run && chg && !sat) chg_cnt <= chg_cnt + 1'b1;
  end

endmodule

// File: tb/tb_aoi_4input.sv
// Bench for aoi_4input: two configurations share one input bus,
// checked against a truth table and a sample scoreboard.
module tb_aoi_4input;

  localparam int PA = 1;
  localparam int PB = 3;

  logic       clk;
  logic       rst;
  logic [3:0] x;
  logic       y_a, y_b, y_q_a, y_q_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  logic [15:0] ttv = 16'h0777;

  int n_chk = 0;
  int n_err = 0;

  aoi_4input #(.PIPE_STAGES(PA), .CNT_W(2)) u_a (
    .y(y_a), .a(x[3]), .b(x[2]), .c(x[1]), .d(x[0]),
    .clk(clk), .rst(rst), .y_q(y_q_a), .chg_cnt(cnt_a)
  );

  aoi_4input #(.PIPE_STAGES(PB), .CNT_W(8)) u_b (
    .y(y_b), .a(x[3]), .b(x[2]), .c(x[1]), .d(x[0]),
    .clk(clk), .rst(rst), .y_q(y_q_b), .chg_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: samples queued at each live edge, oldest reaches y_q
  logic q_a[$];
  logic q_b[$];
  int   rel_m;
  int   m_cnt_a;
  int   m_cnt_b;
  logic s, old_a, old_b, new_a, new_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_m   = 0;
      q_a.delete();
      q_b.delete();
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (rel_m < 2) begin
      rel_m++;
    end else begin
      s     = ttv[x];
      old_a = (q_a.size() == PA) ? q_a[0] : 1'b1;
      old_b = (q_b.size() == PB) ? q_b[0] : 1'b1;
      q_a.push_back(s);
      q_b.push_back(s);
      if (q_a.size() > PA) void'(q_a.pop_front());
      if (q_b.size() > PB) void'(q_b.pop_front());
      new_a = (q_a.size() == PA) ? q_a[0] : 1'b1;
      new_b = (q_b.size() == PB) ? q_b[0] : 1'b1;
      if (new_a != old_a && m_cnt_a < 3)   m_cnt_a++;
      if (new_b != old_b && m_cnt_b < 255) m_cnt_b++;
    end
  end

  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_y_a", 32'(y_a), 32'(ttv[x]));
      chk("mon_y_b", 32'(y_b), 32'(ttv[x]));
      chk("mon_yq_a", 32'(y_q_a),
          32'((q_a.size() == PA) ? q_a[0] : 1'b1));
      chk("mon_yq_b", 32'(y_q_b),
          32'((q_b.size() == PB) ? q_b[0] : 1'b1));
      chk("mon_cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      chk("mon_cnt_b", 32'(cnt_b), 32'(m_cnt_b));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    x   = 4'd0;
    #1 mon_en = 1'b1;

    // Held in reset: y is live, registered side frozen
    @(negedge clk);
    #2;
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      #1;
      chk("rst_y", 32'(y_a), 32'(ttv[i]));
      chk("rst_yq_a", 32'(y_q_a), 32'd1);
      chk("rst_yq_b", 32'(y_q_b), 32'd1);
      chk("rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("rst_cnt_b", 32'(cnt_b), 32'd0);
      #14;
    end

    // Release, then 0000 -> 0011 ahead of a sampling edge
    x = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("p1_pre_yq", 32'(y_q_a), 32'd1);
    x = 4'b0011;
    @(posedge clk);
    #1;
    chk("p1_yq", 32'(y_q_a), 32'd0);
    chk("p1_cnt", 32'(cnt_a), 32'd1);
    @(negedge clk);
    x = 4'd0;

    // Single-cycle {a,b}=11 pulse through the three-stage copy
    do_reset();
    x = 4'b1100;
    @(negedge clk);
    x = 4'd0;
    #1 chk("p3_e0", 32'(y_q_b), 32'd1);
    @(negedge clk);
    chk("p3_e1", 32'(y_q_b), 32'd1);
    @(negedge clk);
    chk("p3_e2", 32'(y_q_b), 32'd0);
    @(negedge clk);
    chk("p3_e3", 32'(y_q_b), 32'd1);
    chk("p3_cnt", 32'(cnt_b), 32'd2);

    // Toggle every cycle; 2-bit counter must pin at 3
    do_reset();
    for (int i = 0; i < 10; i++) begin
      x = (i % 2 == 0) ? 4'b1100 : 4'b0000;
      @(negedge clk);
    end
    chk("sat_cnt", 32'(cnt_a), 32'd3);

    // Asynchronous reset between edges, mid-toggle
    x = 4'b1100;
    @(negedge clk);
    x = 4'b0000;
    @(negedge clk);
    x = 4'b1100;
    #3 rst = 1'b1;
    #1;
    chk("arst_yq_a", 32'(y_q_a), 32'd1);
    chk("arst_yq_b", 32'(y_q_b), 32'd1);
    chk("arst_cnt_a", 32'(cnt_a), 32'd0);
    chk("arst_cnt_b", 32'(cnt_b), 32'd0);
    chk("arst_y", 32'(y_a), 32'd0);
    x = 4'b0000;
    #1 chk("arst_y2", 32'(y_a), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Exhaustive sweep out of reset, 15 ns per step
    @(negedge clk);
    #2;
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      #1 chk("sweep_y", 32'(y_a), 32'(ttv[i]));
      #14;
    end
    x = 4'd0;
    repeat (5) @(negedge clk);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
